// File: rtl/fmul_mantissa_multiplier_seq.sv
// fmul_mantissa_multiplier_seq: iterative FP32 multiply front-end (sign, exponent, shift-add 48-bit mantissa product)
// Ports: clk, rst_n (async active-low); start/busy/done handshake; op_a, op_b FP32 operands;
//        out_s sign, out_e clamped biased exponent, out_m 48-bit product (leading one at bit 46),
//        out_zero, out_special (Inf/NaN operand), exp_ovf, exp_unf.
module fmul_mantissa_multiplier_seq #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic        out_s,
  output logic [7:0]  out_e,
  output logic [47:0] out_m,
  output logic        out_zero,
  output logic        out_special,
  output logic        exp_ovf,
  output logic        exp_unf
);
  localparam int N = 24 / BITS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;
  state_t state, state_nx;
  logic [23:0] ma, mb, ua, ub;
  logic [7:0] ea, eb;
  logic [47:0] acc, pp, fm;
  logic [4:0] cnt;
  logic signed [9:0] esum, fe;
  logic zero_r, spec_r, accept, ovf, unf;
  assign accept = state == IDLE && start;
  assign busy = state != IDLE;
  assign ua = {|op_a[30:23], op_a[22:0]};
  assign ub = {|op_b[30:23], op_b[22:0]};
  // a zero exponent field behaves as exponent 1 (denormal scale)
  assign ea = op_a[30:23] | {7'b0, ~|op_a[30:23]};
  assign eb = op_b[30:23] | {7'b0, ~|op_b[30:23]};
  // partial product of the multiplicand with the next multiplier digit
  assign pp = 48'(ma) * 48'(mb[BITS_PER_CYCLE-1:0]);
  // carry pre-normalisation: a product >= 2.0 shifts right and bumps the exponent
  assign fm = acc[47] ? acc >> 1 : acc;
  assign fe = esum + $signed({9'b0, acc[47]});
  assign ovf = fe >= 10'sd255;
  assign unf = fe <= 10'sd0;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? MUL : IDLE) : state == MUL ? (cnt == 5'(N - 1) ? FIN : MUL) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0;
      mb <= '0;
      acc <= '0;
      cnt <= '0;
      esum <= '0;
      zero_r <= 1'b0;
      spec_r <= 1'b0;
      done <= 1'b0;
      out_s <= 1'b0;
      out_e <= '0;
      out_m <= '0;
      out_zero <= 1'b0;
      out_special <= 1'b0;
      exp_ovf <= 1'b0;
      exp_unf <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        ma <= ua;
        mb <= ub;
        acc <= '0;
        cnt <= '0;
        esum <= $signed(10'(ea) + 10'(eb) - 10'd127);
        zero_r <= op_a[30:0] == '0 || op_b[30:0] == '0;
        spec_r <= &op_a[30:23] || &op_b[30:23];
        out_s <= op_a[31] ^ op_b[31];
      end else if (state == MUL) begin
        acc <= acc + (pp << (cnt * BITS_PER_CYCLE));
        mb <= mb >> BITS_PER_CYCLE;
        cnt <= cnt + 5'd1;
      end else if (state == FIN) begin
        done <= 1'b1;
        out_m <= zero_r ? '0 : fm;
        out_e <= zero_r ? 8'h00 : ovf ? 8'hFF : unf ? 8'h00 : fe[7:0];
        out_zero <= zero_r;
        out_special <= spec_r;
        exp_ovf <= !zero_r && ovf;
        exp_unf <= !zero_r && unf;
      end
    end
  end
endmodule

// File: doc/fmul_mantissa_multiplier_seq.md
Name: fmul_mantissa_multiplier_seq

Overview:
- Iterative multi-cycle FP32 multiply front-end for the F-extension multiply path.
- Unpacks two single-precision operands, computes the sign and biased exponent, and forms the 48-bit mantissa product by shift-add over several cycles.
- Pre-normalises the bit-47 carry case, then presents exponent and product to the downstream multiplication normaliser, which handles leading-zero shifts of up to 5.
- Start/done handshake replaces the single-cycle combinational multiplier where area matters.

Parameters:
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration. Legal values are 1, 2, 3, 4, 6, 8, 12 (divisors of 24). Iteration count N = 24/BITS_PER_CYCLE.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- op_a  in  32  FP32 operand A, sampled on accept.
- op_b  in  32  FP32 operand B, sampled on accept.
- busy  out  1  high from accept until the done cycle.
- done  out  1  one-cycle pulse; result valid.
- out_s  out  1  product sign.
- out_e  out  8  biased exponent after carry pre-normalisation.
- out_m  out  48  mantissa product; leading one at bit 46, or lower for denormal inputs.
- out_zero  out  1  either operand is ±0.
- out_special  out  1  either operand has exponent field 0xFF (Inf or NaN).
- exp_ovf  out  1  exponent is 255 or more; out_e forced to 0xFF.
- exp_unf  out  1  exponent is 0 or less; out_e forced to 0x00.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. busy, done, out_s, out_e, out_m, out_zero, out_special, exp_ovf and exp_unf all go to 0. Internal accumulator and counter are cleared. Reset mid-operation aborts the operation silently; no done is produced.
- FSM states are IDLE, MUL and FIN.
- IDLE:
  - start=1 at edge T0 → latch operands and go to MUL; busy=1.
  - Unpack: ma = {|ea, fa}, 24 bits (hidden bit 0 when the exponent field is 0). The effective exponent is the field value, or 1 when the field is 0.
  - out_s = sa ^ sb, computed at accept.
  - esum = ea' + eb' − 127, held as a 10-bit signed value.
- MUL:
  - Each edge adds (ma × the low BITS_PER_CYCLE bits of the multiplier) into the 48-bit accumulator at offset count×BITS_PER_CYCLE, then shifts the multiplier right.
  - count runs 0..N−1. After edge T_N, go to FIN.
- FIN (edge T_{N+1}): register the outputs; done=1 and busy=0 for the following cycle; return to IDLE.
  - If product[47]=1: out_m = product>>1, esum+1.
  - Otherwise: out_m = product, esum unchanged.
  - Exponent clamp: esum ≥ 255 → exp_ovf=1, out_e=0xFF. esum ≤ 0 → exp_unf=1, out_e=0x00. Otherwise out_e = esum[7:0].
  - Zero case (out_zero=1): out_m=0 and out_e=0, with no exponent flags. Zero takes priority over the clamp; out_special does not.
- Latency: done is high exactly N+1 edges after the accepting edge (N=12 → 13).
- Result outputs hold their values after done until the next FIN. done itself is a single pulse.
- start while busy=1 is ignored; it is neither queued nor errored.
- start asserted in the done cycle is accepted, since busy=0 in that cycle. Back-to-back throughput is therefore one result per N+2 cycles.
- op_a and op_b may change freely after accept.
- No rounding and no NaN generation in this block; Inf/NaN are flagged only.

Test Plan:
- 1.0×1.0 (0x3F800000, 0x3F800000) → after 13 edges: done=1, out_m=0x400000000000, out_e=0x7F, out_s=0, no flags.
- 1.5×−1.5 (0x3FC00000, 0xBFC00000) → raw product 0x900000000000; expect out_m=0x480000000000, out_e=0x80, out_s=1.
- 0×3.0 (0x00000000, 0x40400000) → out_zero=1, out_m=0, out_e=0, done at edge 13.
- Overflow and underflow:
  - 0x7F000000 × 0x7F000000 → exp_ovf=1, out_e=0xFF.
  - 0x00800000 × 0x00800000 → exp_unf=1, out_e=0x00.
- Handshake:
  - start held high continuously → exactly one done per 14 cycles.
  - Pulsing start mid-MUL changes nothing.
  - rst_n low at iteration 5 → busy=0 and all outputs 0 immediately; no done pulse.
- Parameter sweep BITS_PER_CYCLE ∈ {1, 4, 8} → latencies 25, 7 and 4 edges, with results identical to the random-operand reference model (10k vectors).
